// File: rtl/bf16_stream_accumulator.sv
// ============================================================================
// Module   : bf16_stream_accumulator
// Purpose  : Multi-cycle bfloat16 add/sub reduction over a valid/ready stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bf16_stream_accumulator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_is_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [15:0] C_QNAN = 16'h7FC0;

    state_t        state_q, state_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   op_q, op_d;
    logic          last_q, last_d;
    logic          nan_q, nan_d;
    logic          sign_q, sign_d;
    logic [7:0]    exp_q, exp_d;
    logic [10:0]   siga_q, siga_d;
    logic [10:0]   sigb_q, sigb_d;
    logic          effsub_q, effsub_d;
    logic [11:0]   sum_q, sum_d;
    logic          specnan_q, specnan_d;
    logic          specinf_q, specinf_d;

    // Alignment datapath
    logic [14:0]   w_mag_acc, w_mag_op;
    logic          w_swap;
    logic [15:0]   w_big, w_small;
    logic [7:0]    w_sig_big, w_sig_small;
    logic [7:0]    w_diff;
    logic [10:0]   w_ext_small, w_shifted, w_mask;
    logic [10:0]   w_b_al;
    logic          w_acc_nan, w_op_nan, w_acc_inf, w_op_inf;
    logic          w_nan, w_inf;

    always_comb begin
        w_mag_acc   = (acc_q[14:7] == 8'd0) ? 15'd0 : acc_q[14:0];
        w_mag_op    = (op_q[14:7] == 8'd0)  ? 15'd0 : op_q[14:0];
        w_swap      = (w_mag_op > w_mag_acc);
        w_big       = w_swap ? op_q : acc_q;
        w_small     = w_swap ? acc_q : op_q;
        w_sig_big   = (w_big[14:7] == 8'd0)   ? 8'd0 : {1'b1, w_big[6:0]};
        w_sig_small = (w_small[14:7] == 8'd0) ? 8'd0 : {1'b1, w_small[6:0]};
        w_diff      = w_big[14:7] - w_small[14:7];
        w_ext_small = {w_sig_small, 3'b000};
        w_shifted   = w_ext_small >> w_diff[3:0];
        w_mask      = (11'd1 << w_diff[3:0]) - 11'd1;
        // Beyond 10 positions the smaller operand survives only as sticky
        if (w_diff >= 8'd11) begin
            w_b_al = {10'd0, |w_sig_small};
        end else begin
            w_b_al = {w_shifted[10:1], w_shifted[0] | (|(w_ext_small & w_mask))};
        end

        w_acc_nan = (acc_q[14:7] == 8'hFF) && (acc_q[6:0] != 7'd0);
        w_op_nan  = (op_q[14:7] == 8'hFF)  && (op_q[6:0] != 7'd0);
        w_acc_inf = (acc_q[14:7] == 8'hFF) && (acc_q[6:0] == 7'd0);
        w_op_inf  = (op_q[14:7] == 8'hFF)  && (op_q[6:0] == 7'd0);
        w_nan     = nan_q | w_acc_nan | w_op_nan |
                    (w_acc_inf & w_op_inf & (acc_q[15] ^ op_q[15]));
        w_inf     = w_acc_inf | w_op_inf;
    end

    // Normalise and round
    logic [3:0]        w_lz;
    logic [10:0]       w_m;
    logic signed [9:0] w_e;
    logic              w_rup;
    logic [8:0]        w_rnd;
    logic [6:0]        w_frac;
    logic [15:0]       w_norm_res;

    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i <= 10; i++) begin
            if (sum_q[i]) begin
                w_lz = 4'(10 - i);
            end
        end
        if (sum_q[11]) begin
            w_m = {sum_q[11:2], sum_q[1] | sum_q[0]};
            w_e = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            w_m = sum_q[10:0] << w_lz;
            w_e = $signed({2'b00, exp_q}) - $signed({6'd0, w_lz});
        end
        w_rup = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
        w_rnd = {1'b0, w_m[10:3]} + {8'd0, w_rup};
        if (w_rnd[8]) begin
            w_frac = w_rnd[7:1];
            w_e    = w_e + 10'sd1;
        end else begin
            w_frac = w_rnd[6:0];
        end

        if (specnan_q) begin
            w_norm_res = C_QNAN;
        end else if (specinf_q) begin
            w_norm_res = {sign_q, 8'hFF, 7'd0};
        end else if (sum_q == 12'd0) begin
            w_norm_res = 16'h0000;
        end else if (w_e >= 10'sd255) begin
            w_norm_res = {sign_q, 8'hFF, 7'd0};
        end else if (w_e <= 10'sd0) begin
            w_norm_res = {sign_q, 15'd0};
        end else begin
            w_norm_res = {sign_q, w_e[7:0], w_frac};
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        op_d      = op_q;
        last_d    = last_q;
        nan_d     = nan_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        siga_d    = siga_q;
        sigb_d    = sigb_q;
        effsub_d  = effsub_q;
        sum_d     = sum_q;
        specnan_d = specnan_q;
        specinf_d = specinf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = {in_data[WIDTH-1] ^ in_is_sub, in_data[WIDTH-2:0]};
                    last_d  = in_last;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                sign_d    = w_big[15];
                exp_d     = w_big[14:7];
                siga_d    = {w_sig_big, 3'b000};
                sigb_d    = w_b_al;
                effsub_d  = w_big[15] ^ w_small[15];
                specnan_d = w_nan;
                specinf_d = w_inf;
                state_d   = S_ADD;
            end
            S_ADD: begin
                // Swap guarantees A >= B, so the subtraction never underflows
                sum_d   = effsub_q ? ({1'b0, siga_q} - {1'b0, sigb_q})
                                   : ({1'b0, siga_q} + {1'b0, sigb_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                acc_d   = w_norm_res;
                nan_d   = nan_q | specnan_q;
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d   = 16'h0000;
                    nan_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= 16'h0000;
            op_q      <= 16'h0000;
            last_q    <= 1'b0;
            nan_q     <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= 8'd0;
            siga_q    <= 11'd0;
            sigb_q    <= 11'd0;
            effsub_q  <= 1'b0;
            sum_q     <= 12'd0;
            specnan_q <= 1'b0;
            specinf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            last_q    <= last_d;
            nan_q     <= nan_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            siga_q    <= siga_d;
            sigb_q    <= sigb_d;
            effsub_q  <= effsub_d;
            sum_q     <= sum_d;
            specnan_q <= specnan_d;
            specinf_q <= specinf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_bf16_stream_accumulator.sv
// ============================================================================
// Module   : tb_bf16_stream_accumulator
// Purpose  : Directed self-checking bench for bf16_stream_accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bf16_stream_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_is_sub;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int total;
    int bad;

    bf16_stream_accumulator #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_is_sub (in_is_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one operand; returns after the accepting edge (+1) with in_valid dropped
    task automatic send(input logic [15:0] d, input logic sub, input logic last, output int waited);
        bit accepted;
        waited   = 0;
        accepted = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_is_sub = sub;
        in_last   = last;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(posedge clk);
                accepted = 1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (!accepted) check_value("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge of the last operand
    task automatic get_result(input string tag, input logic [15:0] exp);
        int lat;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check_value({tag, "_lat"}, 32'(lat), 32'd3);
        check_value({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value({tag, "_ovdone"}, {31'd0, out_valid}, 32'd0);
        check_value({tag, "_irdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int w;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_is_sub = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_irdy", {31'd0, in_ready}, 32'd1);
        check_value("rst_ov", {31'd0, out_valid}, 32'd0);
        check_value("rst_data", {16'd0, out_data}, 32'h0);
        rst_n = 1'b1;

        // 3 + 4
        send(16'h4040, 1'b0, 1'b0, w);
        send(16'h4080, 1'b0, 1'b1, w);
        check_value("add2_wait", 32'(w), 32'd3);
        get_result("add2", 16'h40E0);

        // 1 + 2 + 3 + 4
        send(16'h3F80, 1'b0, 1'b0, w);
        send(16'h4000, 1'b0, 1'b0, w);
        check_value("add4_wait1", 32'(w), 32'd3);
        send(16'h4040, 1'b0, 1'b0, w);
        check_value("add4_wait2", 32'(w), 32'd3);
        send(16'h4080, 1'b0, 1'b1, w);
        check_value("add4_wait3", 32'(w), 32'd3);
        get_result("add4", 16'h4120);

        // 4 - 3, 3 - 3
        send(16'h4080, 1'b0, 1'b0, w);
        send(16'h4040, 1'b1, 1'b1, w);
        get_result("sub", 16'h3F80);
        send(16'h4040, 1'b0, 1'b0, w);
        send(16'h4040, 1'b1, 1'b1, w);
        get_result("subzero", 16'h0000);

        // Single negated operand: 0 - 3
        send(16'h4040, 1'b1, 1'b1, w);
        get_result("single_neg", 16'hC040);

        // Overflow to Inf, then Inf + -Inf -> sticky NaN
        send(16'h7F7F, 1'b0, 1'b0, w);
        send(16'h7F7F, 1'b0, 1'b1, w);
        get_result("ovf", 16'h7F80);
        send(16'h7F80, 1'b0, 1'b0, w);
        send(16'hFF80, 1'b0, 1'b0, w);
        send(16'h3F80, 1'b0, 1'b1, w);
        get_result("nan", 16'h7FC0);

        // Output backpressure with a waiting operand
        send(16'h4040, 1'b0, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = 16'h4000;
        in_is_sub = 1'b0;
        in_last   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_value("bp_ov", {31'd0, out_valid}, 32'd1);
            check_value("bp_data", {16'd0, out_data}, 32'h4040);
            check_value("bp_irdy", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value("bp_hs_ov", {31'd0, out_valid}, 32'd0);
        check_value("bp_hs_irdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_value("bp_accept", {31'd0, in_ready}, 32'd0);
        get_result("bp_next", 16'h4000);

        // Reset while in S_ADD
        send(16'h4040, 1'b0, 1'b0, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_value("midrst_irdy", {31'd0, in_ready}, 32'd1);
        check_value("midrst_ov", {31'd0, out_valid}, 32'd0);
        send(16'h3F80, 1'b0, 1'b1, w);
        get_result("postrst", 16'h3F80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
